sd_bus_arb: RTL and testbench

SD_BUS_ARB -- requirements
Module: sd_bus_arb

---
 rtl/sd_pkg.sv | 30 +++
 rtl/sd_wdog.sv | 30 +++
 rtl/sd_bus_arb.sv | 147 ++++++++++++++
 tb/tb_sd_bus_arb.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the SD SPI engines and the bus arbiter:
// arbiter state encoding, requester indices and SD command numbers.
package sd_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } arb_state_t;

    localparam int N_REQ    = 3;
    localparam int REQ_INIT = 0;
    localparam int REQ_RD   = 1;
    localparam int REQ_WR   = 2;

    // Width of the shared watchdog / gap counter.
    localparam int WDOG_W = 10;

    localparam logic [5:0] CMD0  = 6'd0;
    localparam logic [5:0] CMD17 = 6'd17;
    localparam logic [5:0] CMD24 = 6'd24;

    function automatic logic [N_REQ-1:0] req_onehot(input int idx);
        logic [N_REQ-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/sd_wdog.sv
// Shared up-counter for the grant watchdog and the inter-grant gap.
// Clears on load, counts while enabled, flags when it equals the limit.
module sd_wdog
    import sd_pkg::*;
#(
    parameter int W = WDOG_W
) (
    input  logic         SD_CLK,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(negedge SD_CLK or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == limit);

endmodule

// File: rtl/sd_bus_arb.sv
// Arbiter for the shared SD SPI bus between the init, read and write
// engines. All state advances on the falling (drive) edge of SD_CLK.
//
// state   | meaning
// S_IDLE  | bus free, arbitrate among eligible requesters
// S_GRANT | one requester owns SD_CS/SD_DATAIN, watchdog running
// S_GAP   | bus forced idle between grants
module sd_bus_arb
    import sd_pkg::*;
#(
    parameter int GAP_CYCLES = 8,
    parameter int TIMEOUT    = 1023
) (
    input  logic       SD_CLK,
    input  logic       rst_n,
    input  logic       init_req,
    input  logic       init_cs,
    input  logic       init_din,
    input  logic       init_done,
    input  logic       rd_req,
    input  logic       rd_cs,
    input  logic       rd_din,
    input  logic       wr_req,
    input  logic       wr_cs,
    input  logic       wr_din,
    output logic [2:0] gnt,
    output logic       SD_CS,
    output logic       SD_DATAIN,
    output logic       busy,
    output logic       timeout_err
);

    // The idle arbitration cycle is the last of the GAP_CYCLES bus-idle
    // cycles, so the GAP state itself lasts one cycle less.
    localparam int GAP_LEN = GAP_CYCLES - 1;
    localparam logic [WDOG_W-1:0] GRANT_LIM = WDOG_W'(TIMEOUT - 1);
    localparam logic [WDOG_W-1:0] GAP_LIM   = WDOG_W'((GAP_LEN > 1) ? GAP_LEN - 1 : 0);

    arb_state_t        state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  mask_q, mask_d;
    logic              rr_wr_q, rr_wr_d;
    logic              tmo_q, tmo_d;

    logic [N_REQ-1:0]  req_v, cs_v, din_v, elig, pick;
    logic              held, done_lost;
    logic              wd_load, wd_en, wd_tc;
    logic [WDOG_W-1:0] wd_limit;

    assign req_v = {wr_req, rd_req, init_req};
    assign cs_v  = {wr_cs,  rd_cs,  init_cs};
    assign din_v = {wr_din, rd_din, init_din};

    // Read and write may only use the card once it is initialised.
    assign elig = req_v & ~mask_q & {init_done, init_done, 1'b1};

    always_ff @(negedge SD_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            mask_q  <= '0;
            rr_wr_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            mask_q  <= mask_d;
            rr_wr_q <= rr_wr_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_wr_d   = rr_wr_q;
        tmo_d     = 1'b0;
        pick      = '0;
        held      = |(gnt_q & req_v);
        done_lost = ~init_done & (gnt_q[REQ_RD] | gnt_q[REQ_WR]);
        // A watchdog mask stays until its requester is seen low once.
        mask_d    = mask_q & req_v;

        case (state_q)
            S_IDLE: begin
                if (elig[REQ_INIT]) begin
                    pick = req_onehot(REQ_INIT);
                end else if (elig[REQ_RD] && elig[REQ_WR]) begin
                    pick = rr_wr_q ? req_onehot(REQ_WR) : req_onehot(REQ_RD);
                end else if (elig[REQ_RD]) begin
                    pick = req_onehot(REQ_RD);
                end else if (elig[REQ_WR]) begin
                    pick = req_onehot(REQ_WR);
                end
                if (pick != '0) begin
                    state_d = S_GRANT;
                    gnt_d   = pick;
                    if (!pick[REQ_INIT]) begin
                        rr_wr_d = ~rr_wr_q;
                    end
                end
            end
            S_GRANT: begin
                if (!held || done_lost || wd_tc) begin
                    gnt_d   = '0;
                    state_d = (GAP_LEN > 0) ? S_GAP : S_IDLE;
                    if (held && !done_lost) begin
                        tmo_d  = 1'b1;
                        mask_d = mask_d | gnt_q;
                    end
                end
            end
            S_GAP: begin
                if (wd_tc) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase

        wd_load  = (state_d != state_q);
        wd_en    = (state_q != S_IDLE);
        wd_limit = (state_q == S_GRANT) ? GRANT_LIM : GAP_LIM;
    end

    sd_wdog #(
        .W(WDOG_W)
    ) u_wdog (
        .SD_CLK(SD_CLK),
        .rst_n (rst_n),
        .load  (wd_load),
        .en    (wd_en),
        .limit (wd_limit),
        .tc    (wd_tc)
    );

    // gnt is non-zero only in S_GRANT, so the bus idles high elsewhere.
    assign SD_CS       = (gnt_q == '0) ? 1'b1 : |(gnt_q & cs_v);
    assign SD_DATAIN   = (gnt_q == '0) ? 1'b1 : |(gnt_q & din_v);
    assign gnt         = gnt_q;
    assign busy        = (state_q != S_IDLE);
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_sd_bus_arb.sv
// Directed self-checking bench for sd_bus_arb with default parameters.
module tb_sd_bus_arb;

    logic       SD_CLK = 1'b0;
    logic       rst_n = 1'b0;
    logic       init_req = 1'b0, init_cs = 1'b1, init_din = 1'b1, init_done = 1'b0;
    logic       rd_req = 1'b0, rd_cs = 1'b1, rd_din = 1'b1;
    logic       wr_req = 1'b0, wr_cs = 1'b1, wr_din = 1'b1;
    logic [2:0] gnt;
    logic       SD_CS, SD_DATAIN, busy, timeout_err;

    int n_assert = 0;
    int n_fail   = 0;
    int cnt;
    bit flag;

    always #5 SD_CLK = ~SD_CLK;

    sd_bus_arb dut (
        .SD_CLK     (SD_CLK),
        .rst_n      (rst_n),
        .init_req   (init_req),
        .init_cs    (init_cs),
        .init_din   (init_din),
        .init_done  (init_done),
        .rd_req     (rd_req),
        .rd_cs      (rd_cs),
        .rd_din     (rd_din),
        .wr_req     (wr_req),
        .wr_cs      (wr_cs),
        .wr_din     (wr_din),
        .gnt        (gnt),
        .SD_CS      (SD_CS),
        .SD_DATAIN  (SD_DATAIN),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    task automatic tick();
        @(negedge SD_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ticks until a grant appears, counting SD_CS=1 cycles on the way.
    task automatic wait_grant(input string tag, input logic [2:0] exp,
                              input int exp_gap, input bit chk_gap, input int idle0);
        int idle;
        bit got;
        idle = idle0;
        got  = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (gnt != 3'b000) begin
                got = 1'b1;
                break;
            end
            if (SD_CS) idle++;
        end
        chk({tag, " granted"}, 32'(got), 32'd1);
        chk(tag, 32'(gnt), 32'(exp));
        chk({tag, " cs"}, 32'(SD_CS), 32'd0);
        if (chk_gap) chk({tag, " gap"}, 32'(idle), 32'(exp_gap));
    endtask

    initial begin
        #3;
        chk("rst gnt", 32'(gnt), 32'd0);
        chk("rst cs", 32'(SD_CS), 32'd1);
        chk("rst din", 32'(SD_DATAIN), 32'd1);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst tmo", 32'(timeout_err), 32'd0);
        #9 rst_n = 1'b1;
        tick();
        chk("idle gnt", 32'(gnt), 32'd0);

        // init wins while read is blocked by init_done=0
        init_req = 1'b1; rd_req = 1'b1; init_cs = 1'b0; init_din = 1'b0; rd_cs = 1'b0;
        tick();
        chk("init gnt", 32'(gnt), 32'b001);
        chk("init busy", 32'(busy), 32'd1);
        chk("init cs", 32'(SD_CS), 32'd0);
        chk("init din", 32'(SD_DATAIN), 32'd0);
        init_din = 1'b1; #1;
        chk("init din follow", 32'(SD_DATAIN), 32'd1);
        init_cs = 1'b1; #1;
        chk("init cs follow", 32'(SD_CS), 32'd1);
        init_cs = 1'b0;
        repeat (3) tick();
        chk("init hold", 32'(gnt), 32'b001);
        init_req = 1'b0; init_cs = 1'b1;
        tick();
        chk("init end gnt", 32'(gnt), 32'd0);
        chk("init end busy", 32'(busy), 32'd1);
        chk("init end cs", 32'(SD_CS), 32'd1);
        flag = 1'b0;
        repeat (20) begin
            tick();
            if (gnt != 3'b000) flag = 1'b1;
        end
        chk("rd blocked", 32'(flag), 32'd0);
        chk("rd blocked busy", 32'(busy), 32'd0);
        rd_req = 1'b0; rd_cs = 1'b1;

        // round-robin between read and write
        init_done = 1'b1; rd_cs = 1'b0; wr_cs = 1'b0;
        rd_req = 1'b1; wr_req = 1'b1;
        wait_grant("rr1", 3'b010, 0, 1'b0, 0);
        repeat (2) tick();
        rd_req = 1'b0;
        tick();
        rd_req = 1'b1;
        chk("rr1 release", 32'(gnt), 32'd0);
        wait_grant("rr2", 3'b100, 8, 1'b1, 1);
        repeat (2) tick();
        wr_req = 1'b0;
        tick();
        wr_req = 1'b1;
        chk("rr2 release", 32'(gnt), 32'd0);
        wait_grant("rr3", 3'b010, 8, 1'b1, 1);
        rd_req = 1'b0; wr_req = 1'b0;
        repeat (10) tick();
        chk("rr idle", 32'(busy), 32'd0);

        // watchdog on a held read grant
        rd_req = 1'b1;
        tick();
        chk("wd grant", 32'(gnt), 32'b010);
        cnt = 1;
        for (int i = 0; i < 1100; i++) begin
            tick();
            if (gnt != 3'b010) break;
            cnt++;
        end
        chk("wd hold cycles", 32'(cnt), 32'd1023);
        chk("wd gnt", 32'(gnt), 32'd0);
        chk("wd pulse", 32'(timeout_err), 32'd1);
        chk("wd busy", 32'(busy), 32'd1);
        chk("wd cs", 32'(SD_CS), 32'd1);
        tick();
        chk("wd pulse width", 32'(timeout_err), 32'd0);
        flag = 1'b0;
        repeat (30) begin
            tick();
            if (gnt != 3'b000) flag = 1'b1;
        end
        chk("wd masked", 32'(flag), 32'd0);
        chk("wd masked idle", 32'(busy), 32'd0);
        rd_req = 1'b0;
        tick();
        rd_req = 1'b1;
        tick();
        chk("wd regrant", 32'(gnt), 32'b010);
        rd_req = 1'b0;
        repeat (10) tick();

        // init_done loss during a write grant
        wr_req = 1'b1; wr_cs = 1'b0;
        tick();
        chk("wr gnt", 32'(gnt), 32'b100);
        chk("wr cs", 32'(SD_CS), 32'd0);
        repeat (2) tick();
        init_done = 1'b0;
        tick();
        chk("done loss gnt", 32'(gnt), 32'd0);
        chk("done loss cs", 32'(SD_CS), 32'd1);
        chk("done loss busy", 32'(busy), 32'd1);
        chk("done loss tmo", 32'(timeout_err), 32'd0);
        repeat (6) tick();
        chk("gap last", 32'(busy), 32'd1);
        tick();
        chk("gap to idle", 32'(busy), 32'd0);
        chk("gap idle gnt", 32'(gnt), 32'd0);
        wr_req = 1'b0; init_done = 1'b1;
        repeat (3) tick();

        // async reset in the middle of a read grant
        rd_req = 1'b1; rd_cs = 1'b0;
        tick();
        chk("pre-rst gnt", 32'(gnt), 32'b010);
        chk("pre-rst cs", 32'(SD_CS), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst gnt", 32'(gnt), 32'd0);
        chk("async rst cs", 32'(SD_CS), 32'd1);
        chk("async rst busy", 32'(busy), 32'd0);
        #2 rst_n = 1'b1; wr_req = 1'b1;
        #1;
        chk("no early grant", 32'(gnt), 32'd0);
        tick();
        chk("rr after rst", 32'(gnt), 32'b010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
